// File: rtl/mips_datapath.sv
// Single-cycle MIPS-subset datapath: PC, byte-wide big-endian instruction and
// data memories, 32x32 register file, ALU and main/ALU decode in one block.
module mips_datapath (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] Dout
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREG  = 32;
  localparam int unsigned MEMSZ = 256;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ZERO,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

  logic [XLEN-1:0] pc_q, pc_d, pc_plus4, br_target, j_target;
  logic [XLEN-1:0] instr, simm, rs_val, rt_val, alu_b, alu_res;
  logic [XLEN-1:0] mem_rdata, wr_data;
  logic [XLEN-1:0] rf_q [NREG];
  logic [5:0]      op, funct;
  logic [4:0]      rs, rt, rd, wr_addr;
  logic [7:0]      mem_addr;
  logic            zero, mem_we;

  logic    reg_write, reg_dst_rd, alu_src_imm, mem_write, mem_to_reg, branch, jump;
  alu_op_e alu_op;

  // Instruction memory: read-only, preloaded through dut.im.imem; fetch wraps mod 256
  if (1) begin : im
    logic [7:0] imem [MEMSZ];
    assign instr = {imem[pc_q[7:0]],
                    imem[8'(pc_q[7:0] + 8'd1)],
                    imem[8'(pc_q[7:0] + 8'd2)],
                    imem[8'(pc_q[7:0] + 8'd3)]};
  end

  // Data memory: asynchronous big-endian read, byte-lane write on the rising edge
  if (1) begin : DataMemory
    logic [7:0] dmem [MEMSZ];
    assign mem_rdata = {dmem[mem_addr],
                        dmem[8'(mem_addr + 8'd1)],
                        dmem[8'(mem_addr + 8'd2)],
                        dmem[8'(mem_addr + 8'd3)]};
    // Store commits only outside reset
    always_ff @(posedge clk) begin
      if (mem_we) begin
        dmem[mem_addr]                <= rt_val[31:24];
        dmem[8'(mem_addr + 8'd1)]     <= rt_val[23:16];
        dmem[8'(mem_addr + 8'd2)]     <= rt_val[15:8];
        dmem[8'(mem_addr + 8'd3)]     <= rt_val[7:0];
      end
    end
  end

  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign funct = instr[5:0];
  assign simm  = {{16{instr[15]}}, instr[15:0]};

  // Main and ALU decode; anything unrecognised falls through as a NOP
  always_comb begin
    reg_write   = 1'b0;
    reg_dst_rd  = 1'b0;
    alu_src_imm = 1'b0;
    mem_write   = 1'b0;
    mem_to_reg  = 1'b0;
    branch      = 1'b0;
    jump        = 1'b0;
    alu_op      = ALU_ZERO;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          default: alu_op = ALU_ZERO;
        endcase
        reg_write  = (alu_op != ALU_ZERO);
        reg_dst_rd = 1'b1;
      end
      OP_LW: begin
        reg_write   = 1'b1;
        alu_src_imm = 1'b1;
        mem_to_reg  = 1'b1;
        alu_op      = ALU_ADD;
      end
      OP_SW: begin
        alu_src_imm = 1'b1;
        mem_write   = 1'b1;
        alu_op      = ALU_ADD;
      end
      OP_BEQ: begin
        branch = 1'b1;
        alu_op = ALU_SUB;
      end
      OP_ADDI: begin
        reg_write   = 1'b1;
        alu_src_imm = 1'b1;
        alu_op      = ALU_ADD;
      end
      OP_J: begin
        jump   = 1'b1;
        alu_op = ALU_ZERO;
      end
      default: alu_op = ALU_ZERO;
    endcase
  end

  // Register reads are asynchronous; $0 is hard-wired to zero
  assign rs_val = (rs == 5'd0) ? '0 : rf_q[rs];
  assign rt_val = (rt == 5'd0) ? '0 : rf_q[rt];
  assign alu_b  = alu_src_imm ? simm : rt_val;

  // ALU: wrapping two's-complement arithmetic, signed set-less-than
  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD: alu_res = rs_val + alu_b;
      ALU_SUB: alu_res = rs_val - alu_b;
      ALU_AND: alu_res = rs_val & alu_b;
      ALU_OR:  alu_res = rs_val | alu_b;
      ALU_SLT: alu_res = ($signed(rs_val) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_res = '0;
    endcase
  end

  assign zero     = (alu_res == '0);
  assign Dout     = alu_res;
  assign mem_addr = alu_res[7:0];
  assign mem_we   = mem_write & ~reset;
  assign wr_addr  = reg_dst_rd ? rd : rt;
  assign wr_data  = mem_to_reg ? mem_rdata : alu_res;

  // Next PC: jump, taken branch, or sequential
  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = pc_plus4 + (simm << 2);
  assign j_target  = {pc_plus4[31:28], instr[25:0], 2'b00};

  always_comb begin
    pc_d = pc_plus4;
    if (jump) begin
      pc_d = j_target;
    end else if (branch && zero) begin
      pc_d = br_target;
    end
  end

  // PC register
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Register file: cleared by reset, writes to $0 dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else if (reg_write && (wr_addr != 5'd0)) begin
      rf_q[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_mips_datapath.sv
// Self-checking bench for mips_datapath: directed programs plus random programs
// checked against an instruction-level reference model.
module tb_mips_datapath;

  logic        clk;
  logic        reset;
  logic [31:0] Dout;

  int checks = 0;
  int fails  = 0;

  // Reference architectural state
  logic [7:0]  m_im [256];
  logic [7:0]  m_dm [256];
  logic [31:0] m_rf [32];
  logic [31:0] m_pc;

  mips_datapath dut (
    .clk   (clk),
    .reset (reset),
    .Dout  (Dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input int fn, input int rd, input int rs, input int rt);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rt, input int rs, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] enc_j(input int word_idx);
    return {6'h02, 26'(word_idx)};
  endfunction

  task automatic load_prog(input logic [31:0] p[$]);
    logic [31:0] w;
    for (int i = 0; i < 256; i++) begin
      m_im[i] = 8'h00;
      dut.im.imem[i] = 8'h00;
    end
    for (int k = 0; k < p.size(); k++) begin
      w = p[k];
      for (int b = 0; b < 4; b++) begin
        m_im[4*k+b] = w[31-8*b -: 8];
        dut.im.imem[4*k+b] = w[31-8*b -: 8];
      end
    end
  endtask

  // One instruction of the reference machine; returns the expected ALU result
  task automatic model_step(input bit rst, output logic [31:0] dout, output bit dvalid);
    logic [31:0] ins, a, b, simm, pc4, nxt, wv, addr;
    int op, fn, rs, rt, rd, wa, base;
    bit wr, mw;
    base = int'(m_pc % 256);
    ins  = {m_im[base], m_im[(base+1)%256], m_im[(base+2)%256], m_im[(base+3)%256]};
    op   = int'(ins[31:26]);
    fn   = int'(ins[5:0]);
    rs   = int'(ins[25:21]);
    rt   = int'(ins[20:16]);
    rd   = int'(ins[15:11]);
    a    = m_rf[rs];
    b    = m_rf[rt];
    simm = {{16{ins[15]}}, ins[15:0]};
    pc4  = m_pc + 32'd4;
    nxt  = pc4;
    dout = 32'd0;
    dvalid = 1'b1;
    wr = 1'b0; mw = 1'b0; wa = 0; wv = 32'd0;
    case (op)
      'h00: begin
        wr = 1'b1; wa = rd;
        case (fn)
          'h20: dout = a + b;
          'h22: dout = a - b;
          'h24: dout = a & b;
          'h25: dout = a | b;
          'h2A: dout = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: begin dvalid = 1'b0; wr = 1'b0; end
        endcase
        wv = dout;
      end
      'h08: begin dout = a + simm; wr = 1'b1; wa = rt; wv = dout; end
      'h23: begin
        dout = a + simm; addr = dout % 256;
        wr = 1'b1; wa = rt;
        wv = {m_dm[addr], m_dm[(addr+1)%256], m_dm[(addr+2)%256], m_dm[(addr+3)%256]};
      end
      'h2B: begin dout = a + simm; mw = 1'b1; end
      'h04: begin dout = a - b; if (a == b) nxt = pc4 + simm * 4; end
      'h02: begin dout = 32'd0; nxt = {pc4[31:28], ins[25:0], 2'b00}; end
      default: dvalid = 1'b0;
    endcase
    if (rst) begin
      m_pc = 32'd0;
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    end else begin
      if (wr && wa != 0) m_rf[wa] = wv;
      if (mw) begin
        addr = dout % 256;
        for (int k = 0; k < 4; k++) m_dm[(addr+k)%256] = b[31-8*k -: 8];
      end
      m_pc = nxt;
    end
  endtask

  // Drive one cycle, compare Dout against the model before the edge
  task automatic run_cycle(input bit rst, input bit chk, output logic [31:0] obs);
    logic [31:0] ed;
    bit ev;
    @(negedge clk);
    reset = rst;
    #1;
    obs = Dout;
    model_step(rst, ed, ev);
    if (chk && ev) begin
      checks++;
      if (Dout !== ed) begin
        fails++;
        $display("FAIL dout pc=%0h got %h expected %h", dut.pc_q, Dout, ed);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_n(input int n);
    logic [31:0] o;
    for (int i = 0; i < n; i++) run_cycle(1'b0, 1'b1, o);
  endtask

  task automatic check_state(input string tag);
    checks++;
    if (dut.pc_q !== m_pc) begin
      fails++;
      $display("FAIL %s pc got %h expected %h", tag, dut.pc_q, m_pc);
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (dut.rf_q[i] !== m_rf[i]) begin
        fails++;
        $display("FAIL %s reg%0d got %h expected %h", tag, i, dut.rf_q[i], m_rf[i]);
      end
    end
  endtask

  task automatic check_dmem(input string tag, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      checks++;
      if (dut.DataMemory.dmem[i] !== m_dm[i]) begin
        fails++;
        $display("FAIL %s dmem[%0d] got %h expected %h", tag, i, dut.DataMemory.dmem[i], m_dm[i]);
      end
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Reset, first fetch from byte 0, and clearing of the data region used later
  task automatic test_reset();
    logic [31:0] p[$];
    logic [31:0] o;
    for (int k = 0; k < 16; k++) p.push_back(enc_i('h2B, 0, 0, 4*k));
    p.push_back(enc_j(16));
    load_prog(p);
    for (int i = 0; i < 256; i++) m_dm[i] = 8'hxx;
    run_cycle(1'b1, 1'b0, o);
    check_val("reset_pc", dut.pc_q, 32'd0);
    check_state("reset");
    run_cycle(1'b0, 1'b1, o);
    check_val("first_fetch_dout", o, 32'd0);
    check_val("first_fetch_pc", dut.pc_q, 32'd4);
    run_n(17);
    check_dmem("clear", 0, 63);
    check_state("clear");
  endtask

  task automatic test_alu();
    logic [31:0] p[$];
    logic [31:0] o[8];
    logic [31:0] exp_d[8];
    logic [31:0] d;
    p = '{enc_i('h08, 1, 0, 5), enc_i('h08, 2, 0, 3),
          enc_r('h20, 3, 1, 2), enc_r('h22, 4, 1, 2), enc_r('h24, 5, 1, 2),
          enc_r('h25, 6, 1, 2), enc_r('h2A, 7, 1, 2), enc_r('h2A, 8, 2, 1), enc_j(8)};
    exp_d = '{32'd5, 32'd3, 32'd8, 32'd2, 32'd1, 32'd7, 32'd0, 32'd1};
    load_prog(p);
    run_cycle(1'b1, 1'b1, d);
    for (int i = 0; i < 8; i++) run_cycle(1'b0, 1'b1, o[i]);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (o[i] !== exp_d[i]) begin
        fails++;
        $display("FAIL alu_dout step%0d got %h expected %h", i, o[i], exp_d[i]);
      end
    end
    check_val("slt_reg8", dut.rf_q[8], 32'd1);
    check_val("sub_reg4", dut.rf_q[4], 32'd2);
    check_state("alu");
  endtask

  task automatic test_memory();
    logic [31:0] p[$];
    logic [31:0] o0, o1, o2;
    p = '{enc_i('h08, 1, 0, 5), enc_i('h2B, 1, 0, 24), enc_i('h23, 9, 0, 24), enc_j(3)};
    load_prog(p);
    run_cycle(1'b1, 1'b1, o0);
    run_cycle(1'b0, 1'b1, o0);
    run_cycle(1'b0, 1'b1, o1);
    run_cycle(1'b0, 1'b1, o2);
    check_val("sw_dout", o1, 32'h18);
    check_val("lw_dout", o2, 32'h18);
    check_val("dmem24_27", {dut.DataMemory.dmem[24], dut.DataMemory.dmem[25],
                            dut.DataMemory.dmem[26], dut.DataMemory.dmem[27]}, 32'h0000_0005);
    check_val("lw_reg9", dut.rf_q[9], 32'd5);
    check_state("memory");
    check_dmem("memory", 0, 63);
  endtask

  task automatic test_branch();
    logic [31:0] p[$];
    logic [31:0] o;
    p = '{enc_i('h08, 1, 0, 5), enc_i('h08, 2, 0, 3), enc_i('h04, 1, 1, 2),
          enc_i('h08, 10, 0, 1), enc_i('h08, 11, 0, 1), enc_i('h04, 2, 1, 1),
          enc_i('h08, 12, 0, 1), enc_i('h08, 13, 0, 1), enc_j(8)};
    load_prog(p);
    run_cycle(1'b1, 1'b1, o);
    run_n(2);
    run_cycle(1'b0, 1'b1, o);
    check_val("beq_taken_dout", o, 32'd0);
    check_val("beq_taken_pc", dut.pc_q, 32'd20);
    run_cycle(1'b0, 1'b1, o);
    check_val("beq_fall_dout", o, 32'd2);
    check_val("beq_fall_pc", dut.pc_q, 32'd24);
    run_n(3);
    check_val("skip_reg10", dut.rf_q[10], 32'd0);
    check_val("skip_reg11", dut.rf_q[11], 32'd0);
    check_val("fall_reg12", dut.rf_q[12], 32'd1);
    check_val("fall_reg13", dut.rf_q[13], 32'd1);
    check_val("branch_park_pc", dut.pc_q, 32'd32);
    check_state("branch");
  endtask

  task automatic test_jump_zero();
    logic [31:0] p[$];
    logic [31:0] o;
    p = '{enc_i('h08, 1, 0, 7), enc_r('h20, 0, 1, 1), enc_i('h08, 0, 1, 9),
          enc_i('h23, 0, 0, 24), enc_j(0)};
    load_prog(p);
    run_cycle(1'b1, 1'b1, o);
    run_cycle(1'b0, 1'b1, o);
    run_cycle(1'b0, 1'b1, o);
    check_val("add_to_r0_dout", o, 32'd14);
    run_n(2);
    run_cycle(1'b0, 1'b1, o);
    check_val("j_dout", o, 32'd0);
    check_val("j_pc", dut.pc_q, 32'd0);
    check_val("r0_zero", dut.rf_q[0], 32'd0);
    check_state("jump1");
    run_n(5);
    check_val("j_loop_pc", dut.pc_q, 32'd0);
    check_state("jump2");
  endtask

  task automatic test_nop();
    logic [31:0] p[$];
    logic [31:0] o;
    p = '{enc_i('h08, 1, 0, 5), enc_i('h3F, 1, 0, 'h1234), enc_r('h00, 1, 1, 1),
          enc_r('h27, 1, 1, 1)};
    load_prog(p);
    run_cycle(1'b1, 1'b1, o);
    run_n(5);
    check_val("nop_reg1", dut.rf_q[1], 32'd5);
    check_val("nop_pc", dut.pc_q, 32'd20);
    check_state("nop");
  endtask

  task automatic test_mid_reset();
    logic [31:0] p[$];
    logic [31:0] o;
    p = '{enc_i('h08, 1, 0, 5), enc_i('h08, 2, 0, 'h77), enc_i('h2B, 2, 0, 24),
          enc_i('h2B, 1, 0, 28), enc_r('h20, 3, 1, 2), enc_i('h2B, 3, 0, 32),
          enc_r('h22, 4, 2, 1), enc_i('h2B, 4, 0, 36), enc_r('h2A, 5, 1, 2),
          enc_i('h2B, 5, 0, 40), enc_i('h08, 6, 0, 'hFFFF), enc_i('h2B, 6, 0, 44),
          enc_j(12)};
    load_prog(p);
    run_cycle(1'b1, 1'b1, o);
    run_n(2);
    run_cycle(1'b1, 1'b1, o);
    check_val("midrst_sw_dout", o, 32'h18);
    check_val("midrst_dmem24_27", {dut.DataMemory.dmem[24], dut.DataMemory.dmem[25],
                                   dut.DataMemory.dmem[26], dut.DataMemory.dmem[27]}, 32'h0000_0005);
    check_val("midrst_pc", dut.pc_q, 32'd0);
    check_val("midrst_reg2", dut.rf_q[2], 32'd0);
    check_state("midrst");
    run_n(15);
    check_val("rerun_dmem27", 32'(dut.DataMemory.dmem[27]), 32'h77);
    check_val("rerun_dmem35", 32'(dut.DataMemory.dmem[35]), 32'h7C);
    check_val("rerun_dmem47", 32'(dut.DataMemory.dmem[47]), 32'hFF);
    check_dmem("final_dump", 24, 47);
    check_state("rerun");
  endtask

  task automatic test_random();
    logic [31:0] p[$];
    logic [31:0] o;
    int fns[5];
    fns = '{'h20, 'h22, 'h24, 'h25, 'h2A};
    for (int it = 0; it < 4; it++) begin
      p.delete();
      for (int k = 0; k < 40; k++) begin
        case ($urandom_range(0, 5))
          0, 5: p.push_back(enc_r(fns[$urandom_range(0, 4)], $urandom_range(0, 15),
                                  $urandom_range(0, 15), $urandom_range(0, 15)));
          1: p.push_back(enc_i('h08, $urandom_range(0, 15), $urandom_range(0, 15),
                               $urandom_range(0, 65535)));
          2: p.push_back(enc_i('h23, $urandom_range(0, 15), 0, 4 * $urandom_range(0, 15)));
          3: p.push_back(enc_i('h2B, $urandom_range(0, 15), 0, 4 * $urandom_range(0, 15)));
          default: p.push_back(enc_i('h04, $urandom_range(0, 3), $urandom_range(0, 3),
                                     $urandom_range(0, 3)));
        endcase
      end
      p.push_back(enc_j(0));
      load_prog(p);
      run_cycle(1'b1, 1'b1, o);
      run_n(150);
      check_state("random");
      check_dmem("random", 0, 63);
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_alu();
    test_memory();
    test_branch();
    test_jump_zero();
    test_nop();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
